// File: rtl/i2c_slave.sv
// I2C target with 7-bit address, byte write/read and open-drain SDA.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add the SCL/SDA glitch filter.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       I2C_SCL,
    inout  wire        I2C_SDA,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rw,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        WAIT_STOP
    } state_t;

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_s;
    logic       sda_s;
    logic       scl_f;
    logic       sda_f;
    logic       scl_d;
    logic       sda_d;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic [6:0] tx_shift;
    logic       sda_oe;
    logic       ack_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], I2C_SCL};
            sda_sync <= {sda_sync[0], I2C_SDA};
        end
    end

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic [CW-1:0] scl_cnt;
    logic [CW-1:0] sda_cnt;

    // A level is accepted only after FILTER_LEN consecutive new samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_s == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == LAST) begin
                scl_f   <= scl_s;
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
            if (sda_s == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == LAST) begin
                sda_f   <= sda_s;
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_filter_len;

    assign unused_filter_len = (FILTER_LEN != 0);
    assign scl_f = scl_s;
    assign sda_f = sda_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

    assign I2C_SDA = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shift    <= 7'd0;
            tx_shift <= 7'd0;
            sda_oe   <= 1'b0;
            ack_ok   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            rw       <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
                ack_ok  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
                ack_ok  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                unique case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[5:0], sda_f};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (shift == SLAVE_ADDR) begin
                                    rw    <= sda_f;
                                    busy  <= 1'b1;
                                    state <= ADDR_ACK;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    // sda_oe doubles as the phase flag of the ACK slot.
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                bit_cnt <= 3'd0;
                                if (rw) begin
                                    state    <= READ;
                                    tx_req   <= 1'b1;
                                    tx_shift <= tx_data[6:0];
                                    sda_oe   <= ~tx_data[7];
                                end else begin
                                    state  <= WRITE;
                                    sda_oe <= 1'b0;
                                end
                            end
                        end
                    end
                    WRITE: begin
                        if (scl_rise) begin
                            shift   <= {shift[5:0], sda_f};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data  <= {shift, sda_f};
                                rx_valid <= 1'b1;
                                state    <= WRITE_ACK;
                            end
                        end
                    end
                    WRITE_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WRITE;
                            end
                        end
                    end
                    READ: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd0;
                                ack_ok  <= 1'b0;
                                state   <= READ_ACK;
                            end else begin
                                bit_cnt  <= bit_cnt + 3'd1;
                                sda_oe   <= ~tx_shift[6];
                                tx_shift <= {tx_shift[5:0], 1'b0};
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise) begin
                            if (sda_f) begin
                                state <= WAIT_STOP;
                                busy  <= 1'b0;
                            end else begin
                                ack_ok <= 1'b1;
                            end
                        end else if (scl_fall && ack_ok) begin
                            ack_ok   <= 1'b0;
                            state    <= READ;
                            tx_req   <= 1'b1;
                            tx_shift <= tx_data[6:0];
                            sda_oe   <= ~tx_data[7];
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: table of transfers plus
// hand-written restart, reset and glitch sequences.
module tb_i2c_slave;

    localparam int Q = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda_bus;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rw;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;
    int rxv_cnt = 0;
    int txr_cnt = 0;
    int dut_low_cnt = 0;

    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave dut (
        .clk      (clk),
        .rst      (rst),
        .I2C_SCL  (scl),
        .I2C_SDA  (sda_bus),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rw       (rw),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid) rxv_cnt <= rxv_cnt + 1;
        if (tx_req) txr_cnt <= txr_cnt + 1;
        if (!sda_low && sda_bus === 1'b0) dut_low_cnt <= dut_low_cnt + 1;
    end

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       exp_ack;
        logic [7:0] exp_rx;
        int         exp_rxv;
        int         exp_txr;
        logic       exp_busy;
        logic       exp_rw;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_low = 1'b0;
        wait_q();
        scl = 1'b1;
        wait_q();
        sda_low = 1'b1;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic bus_stop();
        sda_low = 1'b1;
        wait_q();
        scl = 1'b1;
        wait_q();
        sda_low = 1'b0;
        wait_q();
        wait_q();
    endtask

    task automatic clock_pulse();
        wait_q();
        scl = 1'b1;
        wait_q();
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch,
                              output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_low = !b[i];
            wait_q();
            scl = 1'b1;
            wait_q();
            if (i == glitch) begin
                scl = 1'b0;
                repeat (2) @(negedge clk);
                scl = 1'b1;
            end
            wait_q();
            scl = 1'b0;
            wait_q();
        end
        sda_low = 1'b0;
        wait_q();
        scl = 1'b1;
        wait_q();
        ack = sda_bus;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] v);
        v = 8'h00;
        sda_low = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_q();
            scl = 1'b1;
            wait_q();
            v = {v[6:0], sda_bus};
            wait_q();
            scl = 1'b0;
            wait_q();
        end
        sda_low = !nack;
        clock_pulse();
        sda_low = 1'b0;
    endtask

    logic [7:0] rd;
    logic       ack;
    int         rb;
    int         tb0;
    int         lb;
    vec_t       v;

    initial begin
        vecs[0] = '{8'hA0, 8'hA5, 1'b0, 8'hA5, 1, 0, 1'b1, 1'b0};
        vecs[1] = '{8'hA1, 8'h3C, 1'b0, 8'hA5, 0, 1, 1'b1, 1'b1};
        vecs[2] = '{8'hA2, 8'h5A, 1'b1, 8'hA5, 0, 0, 1'b0, 1'b1};
        vecs[3] = '{8'hA0, 8'h00, 1'b0, 8'h00, 1, 0, 1'b1, 1'b0};
        vecs[4] = '{8'hA1, 8'hFF, 1'b0, 8'h00, 0, 1, 1'b1, 1'b1};
        vecs[5] = '{8'h20, 8'hC3, 1'b1, 8'h00, 0, 0, 1'b0, 1'b1};
        vecs[6] = '{8'hA0, 8'h81, 1'b0, 8'h81, 1, 0, 1'b1, 1'b0};

        repeat (4) @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_tx_req", 32'(tx_req), 32'h0);
        check("rst_rw", 32'(rw), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_sda", 32'(sda_bus), 32'h1);
        rst = 1'b0;
        wait_q();

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            rb = rxv_cnt;
            tb0 = txr_cnt;
            lb = dut_low_cnt;
            tx_data = v.data;
            bus_start();
            write_byte(v.addr, -1, ack);
            check("addr_ack", 32'(ack), 32'(v.exp_ack));
            check("busy_addr", 32'(busy), 32'(v.exp_busy));
            check("rw", 32'(rw), 32'(v.exp_rw));
            if (!v.exp_ack) begin
                if (v.addr[0]) begin
                    read_byte(1'b1, rd);
                    check("rd_data", 32'(rd), 32'(v.data));
                    check("busy_nack", 32'(busy), 32'h0);
                end else begin
                    write_byte(v.data, -1, ack);
                    check("data_ack", 32'(ack), 32'h0);
                end
            end
            bus_stop();
            check("busy_stop", 32'(busy), 32'h0);
            check("rx_data", 32'(rx_data), 32'(v.exp_rx));
            check("rx_valid_cnt", 32'(rxv_cnt - rb), 32'(v.exp_rxv));
            check("tx_req_cnt", 32'(txr_cnt - tb0), 32'(v.exp_txr));
            check("sda_driven", 32'(dut_low_cnt != lb), 32'(!v.exp_ack));
        end

        // write, repeated START, two-byte read
        rb = rxv_cnt;
        tb0 = txr_cnt;
        tx_data = 8'h96;
        bus_start();
        write_byte(8'hA0, -1, ack);
        check("rs_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h11, -1, ack);
        check("rs_data_ack", 32'(ack), 32'h0);
        bus_start();
        write_byte(8'hA1, -1, ack);
        check("rs_raddr_ack", 32'(ack), 32'h0);
        check("rs_rw", 32'(rw), 32'h1);
        check("rs_busy", 32'(busy), 32'h1);
        tx_data = 8'h69;
        read_byte(1'b0, rd);
        check("rs_rd0", 32'(rd), 32'h96);
        read_byte(1'b1, rd);
        check("rs_rd1", 32'(rd), 32'h69);
        check("rs_busy_nack", 32'(busy), 32'h0);
        bus_stop();
        check("rs_rx_data", 32'(rx_data), 32'h11);
        check("rs_rxv_cnt", 32'(rxv_cnt - rb), 32'd1);
        check("rs_txr_cnt", 32'(txr_cnt - tb0), 32'd2);

        // reset during bit 4 of a read byte of all zeros
        tx_data = 8'h00;
        bus_start();
        write_byte(8'hA1, -1, ack);
        check("mr_addr_ack", 32'(ack), 32'h0);
        repeat (3) clock_pulse();
        check("mr_bit4_low", 32'(sda_bus), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mr_sda_rel", 32'(sda_bus), 32'h1);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_rw", 32'(rw), 32'h0);
        check("mr_rx_data", 32'(rx_data), 32'h00);
        check("mr_rx_valid", 32'(rx_valid), 32'h0);
        check("mr_tx_req", 32'(tx_req), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        lb = dut_low_cnt;
        repeat (6) clock_pulse();
        check("mr_ignored", 32'(dut_low_cnt - lb), 32'd0);
        bus_stop();
        bus_start();
        write_byte(8'hA0, -1, ack);
        check("mr_next_ack", 32'(ack), 32'h0);
        write_byte(8'h77, -1, ack);
        check("mr_next_dack", 32'(ack), 32'h0);
        bus_stop();
        check("mr_next_rx", 32'(rx_data), 32'h77);

        // 2-cycle SCL low glitch inside the high phase of data bit 4
        rb = rxv_cnt;
        bus_start();
        write_byte(8'hA0, -1, ack);
        check("gl_addr_ack", 32'(ack), 32'h0);
        write_byte(8'hA5, 4, ack);
        bus_stop();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        check("gl_rx_data", 32'(rx_data), 32'hA5);
`else
        check("gl_rx_data", 32'(rx_data), 32'hA2);
`endif
        check("gl_rxv_cnt", 32'(rxv_cnt - rb), 32'd1);
        check("gl_busy", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SLAVE_ADDR  7'h50  7-bit address this target answers to.
REQ-002 FILTER_LEN  3  consecutive equal samples needed to accept an SCL/SDA level change (used only with I2C_SLAVE_GLITCH_FILTER_EN).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 I2C_SCL  input  1  bus clock from the controller, asynchronous to clk.
REQ-006 I2C_SDA  inout  1  open-drain data; the block drives only 0 or Z, never 1.
REQ-007 tx_data  input  8  read-transfer byte, captured on tx_req.
REQ-008 tx_req  output  1  one-cycle pulse when tx_data is captured.
REQ-009 rx_data  output  8  last byte written by the controller.
REQ-010 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-011 rw  output  1  R/W bit of the current addressed transfer (1 = read).
REQ-012 busy  output  1  high from an address match until STOP, repeated START or NACK-terminated read.

Function
REQ-013 SCL and SDA shall pass through 2-flop synchronizers; edge and condition detection shall use the synchronized values only.
REQ-014 START: synchronized SDA 1->0 while SCL high; STOP: SDA 0->1 while SCL high; both recognised in every state.
REQ-015 States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
REQ-016 START, including repeated START, shall go to ADDR with the bit counter at 0 from any state; STOP shall go to IDLE and deassert busy.
REQ-017 Input bits shall be sampled on SCL rising edges, MSB first; SDA output shall change only on the clk cycle after an SCL falling edge is detected.
REQ-018 ADDR: after the 8th rising edge, {addr[6:0], rw} is complete; a match goes to ADDR_ACK, rw updates and busy rises; a mismatch goes to WAIT_STOP with SDA released.
REQ-019 ADDR_ACK/WRITE_ACK: drive SDA low from the next SCL fall until the following SCL fall, then release.
REQ-020 WRITE: on the 8th rising edge, rx_data shall update and rx_valid pulse for exactly one cycle; next state WRITE_ACK, which always ACKs and then returns to WRITE.
REQ-021 READ entry: on the SCL fall that ends ADDR_ACK, or that ends READ_ACK when the controller ACKed, tx_data shall be latched and tx_req pulsed in the same cycle; bit 7 is presented immediately.
REQ-022 READ: bit n shall be driven as 0, or released for a 1, after each SCL fall; after the 8th bit, SDA is released and the state goes to READ_ACK.
REQ-023 READ_ACK: controller SDA sampled on SCL rise; 0 (ACK) continues READ; 1 (NACK) goes to WAIT_STOP and clears busy.
REQ-024 WAIT_STOP shall keep SDA released and ignore bits until START or STOP.
REQ-025 START/STOP seen mid-byte shall abort the byte: no rx_valid, SDA released the same cycle.
REQ-026 Bit counter is 3 bits and wraps 7->0 at each byte boundary; no overflow is possible.

Reset
REQ-027 With rst high at a clk edge: state IDLE, SDA released (Z), rx_data=8'h00, rx_valid=0, tx_req=0, rw=0, busy=0, synchronizers and filter loaded with 1.
REQ-028 Reset mid-transfer shall release SDA in the first cycle; the block ignores the bus until the next START.

Configuration
REQ-029 Macro I2C_SLAVE_GLITCH_FILTER_EN defined: after synchronization, SCL and SDA shall each change their filtered level only after FILTER_LEN consecutive equal samples; pulses shorter than FILTER_LEN clk cycles are suppressed; detection latency grows by FILTER_LEN cycles.
REQ-030 Macro undefined: no filter logic is present; the synchronizer outputs feed detection directly.

Verification
REQ-031 START, 0xA0, data 0xA5, STOP -> ACK after address and after data; rx_data=0xA5, one rx_valid pulse; busy 1 then 0 at STOP.
REQ-032 START, 0xA1, tx_data=0x3C, controller NACK, STOP -> ACK; tx_req pulses once; SDA bits 0,0,1,1,1,1,0,0; WAIT_STOP then IDLE.
REQ-033 START, 0xA2 (address 0x51) -> SDA never driven low; busy stays 0; no rx_valid.
REQ-034 Write 0xA0, 0x11, repeated START, 0xA1, read 2 bytes (ACK, NACK), STOP -> rx_data=0x11; rw=1 after restart; two tx_req pulses.
REQ-035 rst for 1 cycle during bit 4 of a read byte -> SDA Z next cycle; all outputs at reset values; next valid transfer succeeds.
REQ-036 Macro defined, FILTER_LEN=3: 2-cycle low glitch on SCL during a written byte -> no extra bit sampled; rx_data correct. Macro undefined: same glitch corrupts the byte.
